// File: rtl/fb_sched_pkg.sv
// Shared types and default widths for the frame buffer swap scheduler.
package fb_sched_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SWAP  = 2'd1,
      ST_PAINT = 2'd2,
      ST_DONE  = 2'd3
   } sched_state_e;

   localparam int FB_ADDR_BITS = 14;
   localparam int FB_DATA_BITS = 32;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
   parameter int WIDTH = 10
) (
   input  logic             clk,
   input  logic             ext_reset,
   input  logic             inc,
   output logic [WIDTH-1:0] count
);

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (inc && (count_q != {WIDTH{1'b1}}))
         count_d = count_q + WIDTH'(1);
   end

   always_ff @(posedge clk or negedge ext_reset) begin
      if (!ext_reset)
         count_q <= '0;
      else
         count_q <= count_d;
   end

   assign count = count_q;

endmodule

// File: rtl/fb_swap_scheduler.sv
// Double-buffer scheduler: flips frame_toggle on scanner frame start once the
// painter is finished, and registers painter writes into the back buffer.
//
//   state    | meaning
//   ---------+-------------------------------------------------
//   ST_IDLE  | after reset, waiting for the first frame_start
//   ST_SWAP  | one-cycle buffer flip, painter restart queued
//   ST_PAINT | painter rendering, writes accepted
//   ST_DONE  | painter finished, waiting for frame_start
module fb_swap_scheduler
   import fb_sched_pkg::*;
#(
   parameter int ADDR_BITS = FB_ADDR_BITS,
   parameter int DATA_BITS = FB_DATA_BITS,
   parameter int CNT_BITS  = 10
) (
   input  logic                 clk,
   input  logic                 ext_reset,
   input  logic                 frame_start,
   output logic                 painter_start,
   input  logic                 painter_done,
   input  logic                 pix_valid,
   output logic                 pix_ready,
   input  logic [ADDR_BITS-1:0] pix_addr,
   input  logic [DATA_BITS-1:0] pix_data,
   output logic                 fb_write_enable,
   output logic [ADDR_BITS-1:0] fb_write_addr,
   output logic [DATA_BITS-1:0] fb_data_in,
   output logic                 frame_toggle,
   output logic [CNT_BITS-1:0]  frame_count,
   output logic [CNT_BITS-1:0]  overrun_count
);

   sched_state_e         state_q, state_d;
   logic                 frame_toggle_q, frame_toggle_d;
   logic                 painter_start_q, painter_start_d;
   logic [CNT_BITS-1:0]  frame_count_q, frame_count_d;
   logic                 fb_we_q, fb_we_d;
   logic [ADDR_BITS-1:0] fb_addr_q, fb_addr_d;
   logic [DATA_BITS-1:0] fb_data_q, fb_data_d;
   logic                 overrun_inc;
   logic                 accept;

   assign pix_ready = (state_q == ST_PAINT);
   assign accept    = pix_valid && pix_ready;

   always_comb begin
      state_d         = state_q;
      frame_toggle_d  = frame_toggle_q;
      frame_count_d   = frame_count_q;
      painter_start_d = 1'b0;
      overrun_inc     = 1'b0;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (frame_start)
               state_d = ST_SWAP;
         end
         ST_SWAP: begin
            frame_toggle_d  = ~frame_toggle_q;
            frame_count_d   = frame_count_q + CNT_BITS'(1);
            painter_start_d = 1'b1;
            state_d         = ST_PAINT;
         end
         ST_PAINT: begin
            // A done pulse coinciding with frame_start still makes this frame.
            if (painter_done)
               state_d = frame_start ? ST_SWAP : ST_DONE;
            else if (frame_start)
               overrun_inc = 1'b1;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      fb_we_d   = accept;
      fb_addr_d = fb_addr_q;
      fb_data_d = fb_data_q;
      if (accept) begin
         fb_addr_d = pix_addr;
         fb_data_d = pix_data;
      end
   end

   always_ff @(posedge clk or negedge ext_reset) begin
      if (!ext_reset) begin
         state_q         <= ST_IDLE;
         frame_toggle_q  <= 1'b0;
         frame_count_q   <= '0;
         painter_start_q <= 1'b0;
         fb_we_q         <= 1'b0;
         fb_addr_q       <= '0;
         fb_data_q       <= '0;
      end else begin
         state_q         <= state_d;
         frame_toggle_q  <= frame_toggle_d;
         frame_count_q   <= frame_count_d;
         painter_start_q <= painter_start_d;
         fb_we_q         <= fb_we_d;
         fb_addr_q       <= fb_addr_d;
         fb_data_q       <= fb_data_d;
      end
   end

   sat_counter #(
      .WIDTH (CNT_BITS)
   ) u_overrun_cnt (
      .clk       (clk),
      .ext_reset (ext_reset),
      .inc       (overrun_inc),
      .count     (overrun_count)
   );

   assign painter_start   = painter_start_q;
   assign frame_toggle    = frame_toggle_q;
   assign frame_count     = frame_count_q;
   assign fb_write_enable = fb_we_q;
   assign fb_write_addr   = fb_addr_q;
   assign fb_data_in      = fb_data_q;

endmodule

// File: tb/tb_fb_swap_scheduler.sv
// Bench for fb_swap_scheduler: directed table, overrun saturation, mid-frame
// reset, and random traffic against a behavioural model.
module tb_fb_swap_scheduler;

   localparam int AW   = 14;
   localparam int DW   = 32;
   localparam int CW   = 10;
   localparam int OMAX = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          ext_reset;
   logic          frame_start, painter_done, pix_valid;
   logic [AW-1:0] pix_addr;
   logic [DW-1:0] pix_data;
   logic          painter_start, pix_ready, fb_write_enable, frame_toggle;
   logic [AW-1:0] fb_write_addr;
   logic [DW-1:0] fb_data_in;
   logic [CW-1:0] frame_count, overrun_count;

   fb_swap_scheduler #(.ADDR_BITS(AW), .DATA_BITS(DW), .CNT_BITS(CW)) dut (
      .clk             (clk),
      .ext_reset       (ext_reset),
      .frame_start     (frame_start),
      .painter_start   (painter_start),
      .painter_done    (painter_done),
      .pix_valid       (pix_valid),
      .pix_ready       (pix_ready),
      .pix_addr        (pix_addr),
      .pix_data        (pix_data),
      .fb_write_enable (fb_write_enable),
      .fb_write_addr   (fb_write_addr),
      .fb_data_in      (fb_data_in),
      .frame_toggle    (frame_toggle),
      .frame_count     (frame_count),
      .overrun_count   (overrun_count)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: the frame is either being flipped this cycle, being
   // painted, or neither (waiting for the scanner).
   bit            m_flip, m_painting;
   bit            m_ps, m_we;
   int            m_tog, m_frames, m_over;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_data;

   task automatic model_reset();
      m_flip = 0; m_painting = 0; m_ps = 0; m_we = 0;
      m_tog = 0; m_frames = 0; m_over = 0; m_addr = '0; m_data = '0;
   endtask

   task automatic model_edge();
      m_we = m_painting && pix_valid;
      if (m_we) begin
         m_addr = pix_addr;
         m_data = pix_data;
      end
      m_ps = m_flip;
      if (m_flip) begin
         m_tog      = 1 - m_tog;
         m_frames   = (m_frames + 1) % (1 << CW);
         m_flip     = 0;
         m_painting = 1;
      end else if (m_painting) begin
         if (painter_done) begin
            m_painting = 0;
            m_flip     = frame_start;
         end else if (frame_start) begin
            m_over = (m_over < OMAX) ? m_over + 1 : OMAX;
         end
      end else begin
         m_flip = frame_start;
      end
   endtask

   task automatic model_compare();
      check("ready",  pix_ready,       m_painting);
      check("pstart", painter_start,   m_ps);
      check("we",     fb_write_enable, m_we);
      check("waddr",  fb_write_addr,   m_addr);
      check("wdata",  fb_data_in,      m_data);
      check("toggle", frame_toggle,    m_tog);
      check("frames", frame_count,     m_frames);
      check("over",   overrun_count,   m_over);
   endtask

   task automatic drive(input bit fs, input bit pd, input bit pv,
                        input logic [AW-1:0] a, input logic [DW-1:0] d);
      frame_start = fs; painter_done = pd; pix_valid = pv; pix_addr = a; pix_data = d;
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      model_compare();
   endtask

   typedef struct {
      bit            fs, pd, pv;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
      bit            tog, ps, rdy, we;
      logic [AW-1:0] waddr;
      int            fc, ovr;
   } vec_t;

   vec_t vecs[14];

   task automatic check_reset_values(input string tag);
      check({tag, "_ps"},  painter_start,   0);
      check({tag, "_rdy"}, pix_ready,       0);
      check({tag, "_we"},  fb_write_enable, 0);
      check({tag, "_wa"},  fb_write_addr,   0);
      check({tag, "_wd"},  fb_data_in,      0);
      check({tag, "_tog"}, frame_toggle,    0);
      check({tag, "_fc"},  frame_count,     0);
      check({tag, "_ov"},  overrun_count,   0);
   endtask

   initial begin
      //          fs pd pv addr     data          tog ps rdy we waddr    fc ovr
      vecs[0]  = '{1, 0, 0, 14'h0,    32'h0,        0, 0, 0, 0, 14'h0,    0, 0};
      vecs[1]  = '{0, 0, 0, 14'h0,    32'h0,        1, 1, 1, 0, 14'h0,    1, 0};
      vecs[2]  = '{0, 0, 1, 14'h5,    32'hA5A5A5A5, 1, 0, 1, 1, 14'h5,    1, 0};
      vecs[3]  = '{0, 0, 0, 14'h6,    32'h0,        1, 0, 1, 0, 14'h5,    1, 0};
      vecs[4]  = '{1, 0, 0, 14'h0,    32'h0,        1, 0, 1, 0, 14'h5,    1, 1};
      vecs[5]  = '{1, 0, 0, 14'h0,    32'h0,        1, 0, 1, 0, 14'h5,    1, 2};
      vecs[6]  = '{1, 1, 1, 14'h3FFF, 32'hDEADBEEF, 1, 0, 0, 1, 14'h3FFF, 1, 2};
      vecs[7]  = '{0, 0, 0, 14'h0,    32'h0,        0, 1, 1, 0, 14'h3FFF, 2, 2};
      vecs[8]  = '{0, 1, 1, 14'h7,    32'h11,       0, 0, 0, 1, 14'h7,    2, 2};
      vecs[9]  = '{0, 0, 1, 14'h8,    32'h12,       0, 0, 0, 0, 14'h7,    2, 2};
      vecs[10] = '{0, 1, 1, 14'h8,    32'h12,       0, 0, 0, 0, 14'h7,    2, 2};
      vecs[11] = '{1, 0, 1, 14'h8,    32'h12,       0, 0, 0, 0, 14'h7,    2, 2};
      vecs[12] = '{0, 0, 1, 14'h9,    32'h22,       1, 1, 1, 0, 14'h7,    3, 2};
      vecs[13] = '{0, 0, 1, 14'h9,    32'h22,       1, 0, 1, 1, 14'h9,    3, 2};

      ext_reset = 1'b0;
      drive(0, 0, 0, '0, '0);
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check_reset_values("rst");
      ext_reset = 1'b1;

      for (int i = 0; i < 14; i++) begin
         drive(vecs[i].fs, vecs[i].pd, vecs[i].pv, vecs[i].addr, vecs[i].data);
         step();
         check($sformatf("v%0d_tog", i),   frame_toggle,    vecs[i].tog);
         check($sformatf("v%0d_ps", i),    painter_start,   vecs[i].ps);
         check($sformatf("v%0d_rdy", i),   pix_ready,       vecs[i].rdy);
         check($sformatf("v%0d_we", i),    fb_write_enable, vecs[i].we);
         check($sformatf("v%0d_waddr", i), fb_write_addr,   vecs[i].waddr);
         check($sformatf("v%0d_fc", i),    frame_count,     vecs[i].fc);
         check($sformatf("v%0d_ovr", i),   overrun_count,   vecs[i].ovr);
      end
      check("v2_data_kept", fb_data_in, 32'h22);

      // Saturation: keep overrunning well past the counter range.
      drive(0, 0, 0, '0, '0);
      for (int i = 0; i < (1 << CW) + 3; i++) begin
         drive(1, 0, 0, '0, '0);
         step();
      end
      drive(0, 0, 0, '0, '0);
      step();
      check("sat_over", overrun_count, OMAX);
      check("sat_tog",  frame_toggle,  1);

      // Asynchronous reset in the middle of a painted frame with a write in flight.
      drive(0, 0, 1, 14'h123, 32'hCAFEF00D);
      step();
      check("pre_rst_we", fb_write_enable, 1);
      #2;
      ext_reset = 1'b0;
      #1;
      model_reset();
      check_reset_values("midrst");
      drive(0, 0, 0, '0, '0);
      @(posedge clk);
      #1;
      check_reset_values("midrst_hold");
      ext_reset = 1'b1;
      drive(1, 0, 0, '0, '0);
      step();
      check("post_rst_tog0", frame_toggle, 0);
      drive(0, 0, 0, '0, '0);
      step();
      check("post_rst_tog1", frame_toggle,  1);
      check("post_rst_ps",   painter_start, 1);
      check("post_rst_fc",   frame_count,   1);

      // Random traffic.
      for (int i = 0; i < 3000; i++) begin
         drive(($urandom_range(0, 7) == 0), ($urandom_range(0, 5) == 0),
               $urandom_range(0, 1) == 1, AW'($urandom), $urandom);
         step();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
